instruction_fetch_unit: RTL

Parametrised fetch stage for the MIPS core. Holds the program counter, owns a loadable instruction memory, fetches one 32-bit word per cycle and presents it split into registered MIPS fields with a valid flag. Supports stall, branch/jump redirect with squash, and PC wrap-around. It sits between the program loader/testbench and the decode/register-file stage.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/instr_mem.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS field positions, opcodes and fetch state type
package mips_pkg;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;

  localparam logic [5:0]  OP_R_TYPE = 6'h00;
  localparam logic [5:0]  OP_J      = 6'h02;
  localparam logic [5:0]  OP_BEQ    = 6'h04;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - 2^ADDR_W x 32 instruction memory, sync read, read-before-write
module instr_mem
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];

  // The array is never reset so the loader can write during reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // rd_data doubles as the presented-instruction register, so only it is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= NOP_WORD;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS fetch stage with PC, stall, redirect and loadable memory
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        function_code,
  output logic [15:0]       constant,
  output logic [25:0]       jump_target
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              fetch;
  logic              squash;
  logic [31:0]       instr_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_IDLE && start) begin
      state_next = ST_RUN;
    end
  end

  // Redirect wins over stall; a stalled cycle neither fetches nor squashes.
  always_comb begin
    fetch  = 1'b0;
    squash = 1'b0;
    if (state == ST_RUN) begin
      if (redirect_valid) begin
        squash = 1'b1;
      end else if (!stall) begin
        fetch = 1'b1;
      end
    end
  end

  // Redirect is honoured in IDLE too, so software can preset the start address.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (fetch) begin
      pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (squash) begin
      instr_valid <= 1'b0;
    end else if (fetch) begin
      pc_out      <= pc;
      instr_valid <= 1'b1;
    end
  end

  instr_mem #(
    .ADDR_W (ADDR_W)
  ) u_instr_mem (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (fetch),
    .rd_addr (pc),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_data (instr_word)
  );

  assign opcode        = instr_word[OPCODE_LSB +: 6];
  assign rs            = instr_word[RS_LSB +: 5];
  assign rt            = instr_word[RT_LSB +: 5];
  assign rd            = instr_word[RD_LSB +: 5];
  assign shamt         = instr_word[SHAMT_LSB +: 5];
  assign function_code = instr_word[FUNCT_LSB +: 6];
  assign constant      = instr_word[15:0];
  assign jump_target   = instr_word[25:0];

endmodule
